// File: rtl/ldpc_3gpp_dec_obuffer_nbank.sv
// N-bank decoder output buffer: 2^pBNUM_W banks of lane RAM with write/read
// width conversion, per-bank tag/length words and an exact occupancy count.

// One lane of bank RAM. The array is stored at the wider of the two lane
// widths; the narrower side addresses a slice of a stored word.
module ldpc_3gpp_dec_obuffer_nbank_lane #(
   parameter int BNUM_W  = 2,
   parameter int WADDR_W = 8,
   parameter int WDAT_W  = 8,
   parameter int RADDR_W = 8,
   parameter int RDAT_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic                      we,
   input  logic [BNUM_W+WADDR_W-1:0] waddr,
   input  logic [WDAT_W-1:0]         wdat,
   input  logic [BNUM_W+RADDR_W-1:0] raddr,
   output logic [RDAT_W-1:0]         rdat
);
   localparam int MAW = (WADDR_W < RADDR_W) ? WADDR_W : RADDR_W;
   localparam int WSB = WADDR_W - MAW;
   localparam int RSB = RADDR_W - MAW;
   localparam int MW  = (WDAT_W > RDAT_W) ? WDAT_W : RDAT_W;
   localparam int AW  = BNUM_W + MAW;

   logic [MW-1:0]             mem [2**AW];
   logic [BNUM_W+WADDR_W-1:0] wsh;
   logic [BNUM_W+RADDR_W-1:0] rsh;
   logic [MW-1:0]             rword;
   logic [RDAT_W-1:0]         rsel;

   // bank bits sit above the word address, so one shift drops only slice bits
   assign wsh   = waddr >> WSB;
   assign rsh   = raddr >> RSB;
   assign rword = mem[rsh[AW-1:0]];

   generate
      if (WSB == 0) begin : g_wfull
         // write word is as wide as the stored word
         always_ff @(posedge clk)
            if (ena && we) mem[wsh[AW-1:0]] <= wdat;
      end else begin : g_wslice
         // narrow write lands in one slice, selected by the low address bits
         always_ff @(posedge clk)
            if (ena && we)
               for (int s = 0; s < 2**WSB; s++)
                  if (waddr[WSB-1:0] == s[WSB-1:0])
                     mem[wsh[AW-1:0]][s*WDAT_W +: WDAT_W] <= wdat;
      end

      if (RSB == 0) begin : g_rfull
         assign rsel = rword;
      end else begin : g_rslice
         // low read address bits pick the slice; slice 0 is the LSB
         always_comb begin
            rsel = '0;
            for (int s = 0; s < 2**RSB; s++)
               if (raddr[RSB-1:0] == s[RSB-1:0]) rsel = rword[s*RDAT_W +: RDAT_W];
         end
      end
   endgenerate

   // second read stage: registered RAM output
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)   rdat <= '0;
      else if (ena) rdat <= rsel;
endmodule

module ldpc_3gpp_dec_obuffer_nbank #(
   parameter int pBNUM_W  = 2,
   parameter int pWADDR_W = 8,
   parameter int pWDAT_W  = 8,
   parameter int pRADDR_W = 8,
   parameter int pRDAT_W  = 8,
   parameter int pDAT_NUM = 8,
   parameter int pTAG_W   = 4,
   parameter int pLEN_W   = 9
) (
   input  logic                        iclk,
   input  logic                        ireset,
   input  logic                        iclkena,
   input  logic                        iwrite,
   input  logic                        iwfull,
   input  logic [pWADDR_W-1:0]         iwaddr,
   input  logic [pWDAT_W*pDAT_NUM-1:0] iwdat,
   input  logic [pTAG_W-1:0]           iwtag,
   input  logic [pLEN_W-1:0]           iwlen,
   input  logic                        irempty,
   input  logic [pRADDR_W-1:0]         iraddr,
   output logic [pRDAT_W*pDAT_NUM-1:0] ordat,
   output logic [pTAG_W-1:0]           ortag,
   output logic [pLEN_W-1:0]           orlen,
   output logic [pBNUM_W:0]            oused,
   output logic                        oempty,
   output logic                        oemptya,
   output logic                        ofull,
   output logic                        ofulla,
   output logic [1:0]                  oerr
);
   localparam int NB = 2**pBNUM_W;
   localparam logic [pBNUM_W:0] ONE    = (pBNUM_W+1)'(1);
   localparam logic [pBNUM_W:0] NB_V   = {1'b1, {pBNUM_W{1'b0}}};
   localparam logic [pBNUM_W:0] NB_M1  = {1'b0, {pBNUM_W{1'b1}}};

   logic [pBNUM_W-1:0]          wptr, rptr;
   logic [pBNUM_W:0]            used_nxt;
   logic                        acc_w, acc_r, we;
   logic [pTAG_W-1:0]           tag_ram [NB];
   logic [pLEN_W-1:0]           len_ram [NB];
   logic [pBNUM_W+pRADDR_W-1:0] raddr;

   assign acc_w = iwfull  & ~ofull;
   assign acc_r = irempty & ~oempty;
   // data writes are dropped when full so the bank under read stays intact
   assign we    = iwrite  & ~ofull;

   assign ortag = tag_ram[rptr];
   assign orlen = len_ram[rptr];

   // occupancy next value; a simultaneous complete and release cancel out
   always_comb begin
      used_nxt = oused;
      if (acc_w && !acc_r)      used_nxt = oused + ONE;
      else if (!acc_w && acc_r) used_nxt = oused - ONE;
   end

   // pointers, occupancy, status flags and sticky error flags
   always_ff @(posedge iclk or negedge ireset)
      if (!ireset) begin
         wptr    <= '0;
         rptr    <= '0;
         oused   <= '0;
         oempty  <= 1'b1;
         oemptya <= 1'b1;
         ofull   <= 1'b0;
         ofulla  <= (pBNUM_W == 1);
         oerr    <= 2'b00;
      end else if (iclkena) begin
         if (acc_w) wptr <= wptr + 1'b1;
         if (acc_r) rptr <= rptr + 1'b1;
         oused   <= used_nxt;
         oempty  <= (used_nxt == '0);
         oemptya <= (used_nxt <= ONE);
         ofull   <= (used_nxt == NB_V);
         ofulla  <= (used_nxt >= NB_M1);
         if (iwfull  && ofull)  oerr[0] <= 1'b1;
         if (irempty && oempty) oerr[1] <= 1'b1;
      end

   // per-bank tag and length words, committed on an accepted write-complete
   always_ff @(posedge iclk or negedge ireset)
      if (!ireset) begin
         for (int b = 0; b < NB; b++) begin
            tag_ram[b] <= '0;
            len_ram[b] <= '0;
         end
      end else if (iclkena && acc_w) begin
         tag_ram[wptr] <= iwtag;
         len_ram[wptr] <= iwlen;
      end

   // first read stage: registered bank/word address (old rptr on release)
   always_ff @(posedge iclk or negedge ireset)
      if (!ireset)      raddr <= '0;
      else if (iclkena) raddr <= {rptr, iraddr};

   genvar l;
   generate
      for (l = 0; l < pDAT_NUM; l++) begin : g_lane
         ldpc_3gpp_dec_obuffer_nbank_lane #(
            .BNUM_W (pBNUM_W),
            .WADDR_W(pWADDR_W),
            .WDAT_W (pWDAT_W),
            .RADDR_W(pRADDR_W),
            .RDAT_W (pRDAT_W)
         ) u_lane (
            .clk  (iclk),
            .rst_n(ireset),
            .ena  (iclkena),
            .we   (we),
            .waddr({wptr, iwaddr}),
            .wdat (iwdat[l*pWDAT_W +: pWDAT_W]),
            .raddr(raddr),
            .rdat (ordat[l*pRDAT_W +: pRDAT_W])
         );
      end
   endgenerate
endmodule

// File: tb/tb_ldpc_3gpp_dec_obuffer_nbank.sv
// Bench for the N-bank output buffer: directed fill/overflow/simultaneous
// sequences, a long randomized run against a bank-queue model, underflow,
// asynchronous reset and a narrow-read width-conversion instance.
module tb_ldpc_3gpp_dec_obuffer_nbank;
   logic        iclk = 1'b0;
   logic        ireset = 1'b0, iclkena = 1'b1;
   logic        iwrite = 1'b0, iwfull = 1'b0, irempty = 1'b0;
   logic [7:0]  iwaddr = '0, iraddr = '0;
   logic [63:0] iwdat = '0;
   logic [3:0]  iwtag = '0;
   logic [8:0]  iwlen = '0;
   logic [63:0] ordat;
   logic [3:0]  ortag;
   logic [8:0]  orlen;
   logic [2:0]  oused;
   logic        oempty, oemptya, ofull, ofulla;
   logic [1:0]  oerr;

   // second instance: 8-bit write lanes, 4-bit read lanes
   logic        c_write = 1'b0, c_zero = 1'b0;
   logic [7:0]  c_waddr = '0;
   logic [63:0] c_wdat = '0;
   logic [3:0]  c_wtag = '0;
   logic [8:0]  c_wlen = '0;
   logic [8:0]  c_raddr = '0;
   logic [31:0] c_rdat;
   logic [3:0]  c_rtag;
   logic [8:0]  c_rlen;
   logic [2:0]  c_used;
   logic        c_empty, c_emptya, c_full, c_fulla;
   logic [1:0]  c_err;

   always #5 iclk = ~iclk;

   ldpc_3gpp_dec_obuffer_nbank dut (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iwrite(iwrite), .iwfull(iwfull),
      .iwaddr(iwaddr), .iwdat(iwdat), .iwtag(iwtag), .iwlen(iwlen), .irempty(irempty),
      .iraddr(iraddr), .ordat(ordat), .ortag(ortag), .orlen(orlen), .oused(oused),
      .oempty(oempty), .oemptya(oemptya), .ofull(ofull), .ofulla(ofulla), .oerr(oerr));

   ldpc_3gpp_dec_obuffer_nbank #(.pRDAT_W(4), .pRADDR_W(9)) dut_cv (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iwrite(c_write), .iwfull(c_zero),
      .iwaddr(c_waddr), .iwdat(c_wdat), .iwtag(c_wtag), .iwlen(c_wlen), .irempty(c_zero),
      .iraddr(c_raddr), .ordat(c_rdat), .ortag(c_rtag), .orlen(c_rlen), .oused(c_used),
      .oempty(c_empty), .oemptya(c_emptya), .ofull(c_full), .ofulla(c_fulla), .oerr(c_err));

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model: a count of full banks, ring pointers, bank contents
   int          m_used, m_wptr, m_rptr;
   logic [3:0]  m_tag [4];
   logic [8:0]  m_len [4];
   logic [1:0]  m_err;
   logic [63:0] m_mem [4][256];
   int          pa1_bank, pa1_addr;
   bit          pa1_v, p2_v;
   logic [63:0] p2;

   function automatic void model_reset();
      m_used = 0; m_wptr = 0; m_rptr = 0; m_err = 2'b00;
      for (int b = 0; b < 4; b++) begin m_tag[b] = '0; m_len[b] = '0; end
      pa1_bank = 0; pa1_addr = 0; pa1_v = 1'b0;
      p2 = '0; p2_v = 1'b1;
   endfunction

   function automatic void model_update();
      bit full  = (m_used == 4);
      bit empty = (m_used == 0);
      bit aw    = iwfull  && !full;
      bit ar    = irempty && !empty;
      if (iwfull  && full)  m_err[0] = 1'b1;
      if (irempty && empty) m_err[1] = 1'b1;
      // data seen two edges after the address: RAM read before this edge's write
      p2 = m_mem[pa1_bank][pa1_addr]; p2_v = pa1_v;
      pa1_bank = m_rptr; pa1_addr = int'(iraddr); pa1_v = !empty;
      if (iwrite && !full) m_mem[m_wptr][iwaddr] = iwdat;
      if (aw) begin
         m_tag[m_wptr] = iwtag; m_len[m_wptr] = iwlen;
         m_wptr = (m_wptr + 1) % 4;
      end
      if (ar) m_rptr = (m_rptr + 1) % 4;
      m_used = m_used + int'(aw) - int'(ar);
   endfunction

   function automatic logic [63:0] lane_word(input int a, input int b);
      logic [63:0] w;
      for (int l = 0; l < 8; l++) w[l*8 +: 8] = 8'(a + b*16 + l);
      return w;
   endfunction

   task automatic tick();
      @(posedge iclk);
      if (ireset && iclkena) model_update();
      @(negedge iclk);
   endtask

   task automatic check_all(input string ph);
      chk({ph, " oused"},   64'(oused),   64'(m_used));
      chk({ph, " oempty"},  64'(oempty),  64'(m_used == 0));
      chk({ph, " oemptya"}, 64'(oemptya), 64'(m_used <= 1));
      chk({ph, " ofull"},   64'(ofull),   64'(m_used == 4));
      chk({ph, " ofulla"},  64'(ofulla),  64'(m_used >= 3));
      chk({ph, " oerr"},    64'(oerr),    64'(m_err));
      if (m_used > 0) begin
         chk({ph, " ortag"}, 64'(ortag), 64'(m_tag[m_rptr]));
         chk({ph, " orlen"}, 64'(orlen), 64'(m_len[m_rptr]));
      end
      if (p2_v) chk({ph, " ordat"}, ordat, p2);
   endtask

   initial begin
      int dn;
      logic [63:0] e_lo, e_hi;
      model_reset();
      repeat (2) @(negedge iclk);
      chk("rst oused", 64'(oused), 0);
      chk("rst oempty", 64'(oempty), 1);
      chk("rst oemptya", 64'(oemptya), 1);
      chk("rst ofull", 64'(ofull), 0);
      chk("rst ofulla", 64'(ofulla), 0);
      chk("rst oerr", 64'(oerr), 0);
      chk("rst ordat", ordat, 0);
      ireset = 1'b1;

      // fill four banks; the last write of each bank shares the cycle with iwfull
      for (int b = 0; b < 4; b++) begin
         for (int a = 0; a < 256; a++) begin
            iwrite = 1'b1; iwaddr = 8'(a); iwdat = lane_word(a, b);
            iwfull = (a == 255); iwtag = 4'(b + 1);
            iwlen  = (b == 0) ? 9'd256 : (b == 1) ? 9'd200 : (b == 2) ? 9'd100 : 9'd1;
            tick();
         end
         iwrite = 1'b0; iwfull = 1'b0;
         chk("fill oused", 64'(oused), 64'(b + 1));
         chk("fill ofull", 64'(ofull), 64'(b == 3));
         chk("fill ofulla", 64'(ofulla), 64'(b >= 2));
      end
      iraddr = 8'd5; tick(); iraddr = 8'd0; tick();
      chk("rd0 ordat", ordat, lane_word(5, 0));
      chk("rd0 ortag", 64'(ortag), 1);
      chk("rd0 orlen", 64'(orlen), 256);

      // overflow: completion and data both rejected while full
      iwfull = 1'b1; iwtag = 4'd9; iwlen = 9'd3;
      iwrite = 1'b1; iwaddr = 8'd0; iwdat = '1;
      tick();
      iwfull = 1'b0; iwrite = 1'b0;
      chk("ovf oused", 64'(oused), 4);
      chk("ovf oerr", 64'(oerr), 64'(2'b01));
      iraddr = 8'd0; tick(); tick();
      chk("ovf ordat", ordat, lane_word(0, 0));
      chk("ovf ortag", 64'(ortag), 1);

      // release two banks, then complete and release in the same cycle
      irempty = 1'b1; tick(); irempty = 1'b0;
      chk("rel oused", 64'(oused), 3);
      irempty = 1'b1; tick(); irempty = 1'b0;
      chk("rel2 oused", 64'(oused), 2);
      chk("rel2 ortag", 64'(ortag), 3);
      iwfull = 1'b1; irempty = 1'b1; iwtag = 4'd5; iwlen = 9'd7;
      tick();
      iwfull = 1'b0; irempty = 1'b0;
      chk("sim oused", 64'(oused), 2);
      chk("sim ortag", 64'(ortag), 4);
      chk("sim orlen", 64'(orlen), 1);
      irempty = 1'b1; tick(); irempty = 1'b0;
      chk("sim2 oused", 64'(oused), 1);
      chk("sim2 ortag", 64'(ortag), 5);
      chk("sim2 orlen", 64'(orlen), 7);

      // randomized traffic, alternating fill-biased and drain-biased phases
      for (int i = 0; i < 3000; i++) begin
         bit fillp = ((i / 300) % 2) == 0;
         iclkena = ($urandom_range(0, 15) != 0);
         iwrite  = ($urandom_range(0, 3) != 0);
         iwaddr  = 8'($urandom);
         iwdat   = {$urandom, $urandom};
         iwfull  = ($urandom_range(0, fillp ? 5 : 11) == 0);
         irempty = ($urandom_range(0, fillp ? 11 : 5) == 0);
         iwtag   = 4'($urandom);
         iwlen   = 9'($urandom);
         iraddr  = 8'($urandom);
         tick();
         check_all("rnd");
      end
      iclkena = 1'b1; iwrite = 1'b0; iwfull = 1'b0; irempty = 1'b0;

      // drain, then underflow
      dn = 0;
      while (m_used > 0 && dn < 8) begin irempty = 1'b1; tick(); dn++; end
      irempty = 1'b0; tick();
      chk("drain oused", 64'(oused), 0);
      chk("drain oempty", 64'(oempty), 1);
      irempty = 1'b1; tick(); irempty = 1'b0;
      chk("udf oused", 64'(oused), 0);
      chk("udf oerr1", 64'(oerr[1]), 1);
      check_all("udf");

      // asynchronous reset in the middle of a block
      iwrite = 1'b1; iwfull = 1'b1; iwtag = 4'hC; iwlen = 9'd44; tick();
      iwrite = 1'b0; iwfull = 1'b0;
      chk("pre-rst oused", 64'(oused), 1);
      #2 ireset = 1'b0; #1;
      model_reset();
      chk("arst oused", 64'(oused), 0);
      chk("arst oempty", 64'(oempty), 1);
      chk("arst oerr", 64'(oerr), 0);
      chk("arst ortag", 64'(ortag), 0);
      chk("arst orlen", 64'(orlen), 0);
      chk("arst ordat", ordat, 0);
      @(negedge iclk); ireset = 1'b1;

      // width conversion: 8-bit write word 3 -> 4-bit read words 6 (LSB) and 7
      c_write = 1'b1; c_waddr = 8'd3;
      for (int l = 0; l < 8; l++) c_wdat[l*8 +: 8] = 8'hA5 + 8'(l);
      tick();
      c_write = 1'b0;
      for (int l = 0; l < 8; l++) begin
         logic [7:0] v;
         v = 8'hA5 + 8'(l);
         e_lo[l*4 +: 4] = v[3:0];
         e_hi[l*4 +: 4] = v[7:4];
      end
      e_lo[63:32] = '0; e_hi[63:32] = '0;
      c_raddr = 9'd6; tick(); c_raddr = 9'd7; tick();
      chk("cv lo", 64'(c_rdat), e_lo);
      tick();
      chk("cv hi", 64'(c_rdat), e_hi);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
